// File: rtl/rv_pkg.sv
// Shared phase constants, sequencer state encoding and default PC step
// for the multi-cycle RISC-V control path.
package rv_pkg;

    localparam logic [2:0] PH_IF  = 3'd0;
    localparam logic [2:0] PH_ID  = 3'd1;
    localparam logic [2:0] PH_EX  = 3'd2;
    localparam logic [2:0] PH_MEM = 3'd3;
    localparam logic [2:0] PH_WB  = 3'd4;

    localparam logic [31:0] PC_STEP = 32'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

endpackage

// File: rtl/cycle_sequencer_pc_unit.sv
// PC register with branch latch: captures the EX-phase branch decision,
// selects the next PC at WB and flags misaligned taken targets.
module pc_unit #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = rv_pkg::PC_STEP
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        capture,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        wb,
    output logic [31:0] pc,
    output logic        pc_we,
    output logic        misaligned
);

    logic [31:0] pc_q;
    logic [31:0] tgt_q;
    logic        br_q;

    // A taken branch to a non-word address blocks the PC update entirely.
    assign misaligned = br_q && (tgt_q[1:0] != 2'b00);
    assign pc_we      = wb && !misaligned;
    assign pc         = pc_q;

    // Branch latch loads in EX and clears on every WB; PC moves only on pc_we.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q  <= PC_RESET;
            tgt_q <= 32'h0000_0000;
            br_q  <= 1'b0;
        end else begin
            if (capture) begin
                br_q  <= branch_taken;
                tgt_q <= branch_target;
            end
            if (wb) begin
                br_q <= 1'b0;
            end
            if (pc_we) begin
                pc_q <= br_q ? tgt_q : pc_q + PC_STEP;
            end
        end
    end

endmodule

// File: rtl/cycle_sequencer.sv
// Multi-cycle sequencer: drives the IF..WB phase counter, stalls MEM on a
// busy data memory, retires one instruction per pass and traps on halt or
// misaligned branch targets.
module cycle_sequencer #(
    parameter logic [31:0] PC_RESET   = 32'h0000_0000,
    parameter logic [31:0] PC_STEP    = rv_pkg::PC_STEP,
    parameter logic [2:0]  LAST_PHASE = 3'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic        mem_busy,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        halt_req,
    output logic [2:0]  counter,
    output logic [31:0] pc,
    output logic        pc_we,
    output logic        halted,
    output logic        trap_misaligned,
    output logic [31:0] retired
);

    import rv_pkg::*;

    state_t      state_q, state_d;
    logic [2:0]  counter_q, counter_d;
    logic        halt_q, halt_d;
    logic        trap_q, trap_d;
    logic [31:0] retired_q, retired_d;

    logic        wb;
    logic        capture;
    logic        misaligned;

    // WB is gated by reset so no PC write can slip through a reset cycle.
    assign wb      = (state_q == RUN) && (counter_q == LAST_PHASE) && !reset;
    assign capture = (state_q == RUN) && (counter_q == PH_EX);

    pc_unit #(
        .PC_RESET (PC_RESET),
        .PC_STEP  (PC_STEP)
    ) u_pc (
        .clk           (clk),
        .reset         (reset),
        .capture       (capture),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .wb            (wb),
        .pc            (pc),
        .pc_we         (pc_we),
        .misaligned    (misaligned)
    );

    // State, phase, halt latch, trap flag and retire count registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            counter_q <= PH_IF;
            halt_q    <= 1'b0;
            trap_q    <= 1'b0;
            retired_q <= 32'h0000_0000;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            halt_q    <= halt_d;
            trap_q    <= trap_d;
            retired_q <= retired_d;
        end
    end

    // Next-state: phase advance, MEM stall, and WB exit priority.
    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        halt_d    = halt_q;
        trap_d    = trap_q;
        retired_d = retired_q;
        case (state_q)
            IDLE: begin
                counter_d = PH_IF;
                if (run) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (counter_q == LAST_PHASE) begin
                    counter_d = PH_IF;
                    halt_d    = 1'b0;
                    if (misaligned) begin
                        trap_d  = 1'b1;
                        state_d = HALT;
                    end else begin
                        retired_d = retired_q + 32'd1;
                        if (halt_q) begin
                            state_d = HALT;
                        end else if (!run) begin
                            state_d = IDLE;
                        end
                    end
                end else if (counter_q == PH_ID) begin
                    halt_d    = halt_req;
                    counter_d = counter_q + 3'd1;
                end else if (counter_q == PH_MEM) begin
                    counter_d = mem_busy ? counter_q : counter_q + 3'd1;
                end else begin
                    counter_d = counter_q + 3'd1;
                end
            end
            HALT: begin
                counter_d = PH_IF;
            end
            default: begin
                state_d   = HALT;
                counter_d = PH_IF;
            end
        endcase
        // A phase value beyond WB can only come from corruption; park safely.
        if (counter_q > LAST_PHASE) begin
            state_d   = HALT;
            counter_d = PH_IF;
        end
    end

    assign counter         = counter_q;
    assign halted          = (state_q == HALT);
    assign trap_misaligned = trap_q;
    assign retired         = retired_q;

endmodule

// File: tb/tb_cycle_sequencer.sv
// Scoreboard bench for cycle_sequencer: a cycle model predicts the registered
// outputs for each driven cycle; predictions are queued and compared after
// the following clock edge.
module tb_cycle_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic        mem_busy;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        halt_req;
    logic [2:0]  counter;
    logic [31:0] pc;
    logic        pc_we;
    logic        halted;
    logic        trap_misaligned;
    logic [31:0] retired;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cycle_sequencer dut (
        .clk             (clk),
        .reset           (reset),
        .run             (run),
        .mem_busy        (mem_busy),
        .branch_taken    (branch_taken),
        .branch_target   (branch_target),
        .halt_req        (halt_req),
        .counter         (counter),
        .pc              (pc),
        .pc_we           (pc_we),
        .halted          (halted),
        .trap_misaligned (trap_misaligned),
        .retired         (retired)
    );

    typedef struct {
        logic [2:0]  cnt;
        logic [31:0] pc;
        logic        hlt;
        logic        trap;
        logic [31:0] ret;
    } exp_t;

    exp_t sb[$];

    // Reference model state: 0=IDLE 1=RUN 2=HALT
    int          m_state = 0;
    logic [2:0]  m_cnt   = 3'd0;
    logic [31:0] m_pc    = 32'h0;
    logic [31:0] m_ret   = 32'h0;
    logic [31:0] m_tgt   = 32'h0;
    logic        m_br    = 1'b0;
    logic        m_hq    = 1'b0;
    logic        m_trap  = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic exp_we(input logic r);
        logic [1:0] lo;
        lo = m_tgt[1:0];
        return !r && (m_state == 1) && (m_cnt == 3'd4) && !(m_br && (lo != 2'b00));
    endfunction

    task automatic model_step(input logic r, input logic rn, input logic busy,
                              input logic bt, input logic [31:0] tg, input logic hr);
        logic [1:0] lo;
        if (r) begin
            m_state = 0; m_cnt = 3'd0; m_pc = 32'h0; m_ret = 32'h0;
            m_tgt = 32'h0; m_br = 1'b0; m_hq = 1'b0; m_trap = 1'b0;
        end else if (m_state == 0) begin
            if (rn) m_state = 1;
        end else if (m_state == 1) begin
            if (m_cnt == 3'd4) begin
                lo = m_tgt[1:0];
                m_cnt = 3'd0;
                if (m_br && lo != 2'b00) begin
                    m_trap  = 1'b1;
                    m_state = 2;
                end else begin
                    m_pc  = m_br ? m_tgt : m_pc + 32'd4;
                    m_ret = m_ret + 32'd1;
                    if (m_hq) m_state = 2;
                    else if (!rn) m_state = 0;
                end
                m_br = 1'b0;
                m_hq = 1'b0;
            end else if (m_cnt == 3'd1) begin
                m_hq  = hr;
                m_cnt = 3'd2;
            end else if (m_cnt == 3'd2) begin
                m_br  = bt;
                m_tgt = tg;
                m_cnt = 3'd3;
            end else if (m_cnt == 3'd3) begin
                if (!busy) m_cnt = 3'd4;
            end else begin
                m_cnt = m_cnt + 3'd1;
            end
        end
    endtask

    // One clock: drive at negedge, predict, then compare after the edge.
    task automatic cycle(input logic r, input logic rn, input logic busy,
                         input logic bt, input logic [31:0] tg, input logic hr);
        exp_t e;
        exp_t g;
        @(negedge clk);
        reset = r; run = rn; mem_busy = busy;
        branch_taken = bt; branch_target = tg; halt_req = hr;
        #1;
        check("pc_we", {31'b0, pc_we}, {31'b0, exp_we(r)});
        model_step(r, rn, busy, bt, tg, hr);
        e.cnt = m_cnt; e.pc = m_pc; e.hlt = (m_state == 2);
        e.trap = m_trap; e.ret = m_ret;
        sb.push_back(e);
        @(posedge clk);
        #1;
        g = sb.pop_front();
        check("counter", {29'b0, counter}, {29'b0, g.cnt});
        check("pc", pc, g.pc);
        check("halted", {31'b0, halted}, {31'b0, g.hlt});
        check("trap", {31'b0, trap_misaligned}, {31'b0, g.trap});
        check("retired", retired, g.ret);
    endtask

    // Runs one instruction to its WB; off-phase inputs carry hostile noise.
    task automatic do_instr(input int stalls, input logic br, input logic [31:0] tg,
                            input logic hr, input logic drop_run);
        int   budget = 0;
        int   st = stalls;
        logic done = 1'b0;
        logic rn, busy, bt, h;
        logic [31:0] t;
        while (!done) begin
            if (budget >= 40) begin
                check("instr_timeout", budget, 0);
                break;
            end
            budget++;
            busy = 1'b1; bt = 1'b1; t = 32'hDEAD_BEE3; h = 1'b1;
            rn = (drop_run && m_state == 1 && m_cnt >= 3'd2) ? 1'b0 : 1'b1;
            if (m_state == 1) begin
                case (m_cnt)
                    3'd1: h = hr;
                    3'd2: begin bt = br; t = tg; end
                    3'd3: begin
                        busy = (st > 0);
                        if (st > 0) st--;
                    end
                    3'd4: done = 1'b1;
                    default: ;
                endcase
            end
            cycle(1'b0, rn, busy, bt, t, h);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; run = 1'b0; mem_busy = 1'b0;
        branch_taken = 1'b0; branch_target = 32'h0; halt_req = 1'b0;
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        check("rst_counter", {29'b0, counter}, 32'd0);
        check("rst_pc", pc, 32'h0);
        check("rst_retired", retired, 32'd0);

        // Straight-line: three instructions
        for (int i = 0; i < 3; i++) do_instr(0, 1'b0, 32'h0, 1'b0, 1'b0);
        check("t1_pc", pc, 32'h0000_000C);
        check("t1_retired", retired, 32'd3);

        // MEM stall of four extra cycles
        do_instr(4, 1'b0, 32'h0, 1'b0, 1'b0);
        check("t2_pc", pc, 32'h0000_0010);
        check("t2_retired", retired, 32'd4);

        // Taken branch, then sequential with phase-3 branch noise
        do_instr(0, 1'b1, 32'h0000_0040, 1'b0, 1'b0);
        check("t3_branch_pc", pc, 32'h0000_0040);
        do_instr(1, 1'b0, 32'h0, 1'b0, 1'b0);
        check("t3_seq_pc", pc, 32'h0000_0044);

        // PC wrap at the top of the address space
        do_instr(0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
        do_instr(0, 1'b0, 32'h0, 1'b0, 1'b0);
        check("wrap_pc", pc, 32'h0000_0000);

        // Halt request retires the instruction, then parks
        do_instr(0, 1'b0, 32'h0, 1'b1, 1'b0);
        check("t5_pc", pc, 32'h0000_0004);
        check("t5_retired", retired, 32'd9);
        check("t5_halted", {31'b0, halted}, 32'd1);
        for (int i = 0; i < 6; i++)
            cycle(1'b0, i[0], 1'b1, 1'b1, 32'h0000_0100, 1'b1);
        check("t5_hold_counter", {29'b0, counter}, 32'd0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);

        // Misaligned taken target traps without retiring
        do_instr(0, 1'b0, 32'h0, 1'b0, 1'b0);
        do_instr(0, 1'b1, 32'h0000_0042, 1'b0, 1'b0);
        check("t4_trap", {31'b0, trap_misaligned}, 32'd1);
        check("t4_halted", {31'b0, halted}, 32'd1);
        check("t4_pc", pc, 32'h0000_0004);
        check("t4_retired", retired, 32'd1);
        for (int i = 0; i < 6; i++)
            cycle(1'b0, ~i[0], 1'b0, 1'b0, 32'h0, 1'b0);
        check("t4_still_halted", {31'b0, halted}, 32'd1);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        check("t4_rst_trap", {31'b0, trap_misaligned}, 32'd0);
        check("t4_rst_halted", {31'b0, halted}, 32'd0);
        check("t4_rst_retired", retired, 32'd0);

        // run dropped in EX: finishes WB, then IDLE
        do_instr(0, 1'b0, 32'h0, 1'b0, 1'b1);
        check("t6_pc", pc, 32'h0000_0004);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1, 1'b1, 32'h3, 1'b1);
        check("t6_idle_counter", {29'b0, counter}, 32'd0);
        check("t6_idle_retired", retired, 32'd1);

        // Reset during a MEM stall
        for (int i = 0; i < 20 && !(m_state == 1 && m_cnt == 3'd3); i++)
            cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        check("t6_stalled", {29'b0, counter}, 32'd3);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        check("t6_rst_pc", pc, 32'h0000_0000);
        check("t6_rst_counter", {29'b0, counter}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
